// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache with a mandatory idle cycle after each ack.
// Define ARB_ROUND_ROBIN_EN for a round-robin tie-break; otherwise dcache has fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ic_enable_i,
   input  logic              ic_write_i,
   input  logic [ADDR_W-1:0] ic_addr_i,
   input  logic [DATA_W-1:0] ic_data_i,
   output logic [DATA_W-1:0] ic_data_o,
   output logic              ic_ack_o,
   input  logic              dc_enable_i,
   input  logic              dc_write_i,
   input  logic [ADDR_W-1:0] dc_addr_i,
   input  logic [DATA_W-1:0] dc_data_i,
   output logic [DATA_W-1:0] dc_data_o,
   output logic              dc_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o
);
   typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC} state_t;
   state_t state, state_n;
   logic last_gnt;
   logic pick_dc;
`ifdef ARB_ROUND_ROBIN_EN
   // last_gnt high means dcache owned last, so a tie goes to icache
   assign pick_dc = dc_enable_i & (~ic_enable_i | ~last_gnt);
`else
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
   assign pick_dc = dc_enable_i;
`endif
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         last_gnt <= 1'b0;
         grant_o  <= 2'b00;
      end else begin
         state   <= state_n;
         grant_o <= {state_n == GNT_DC, state_n == GNT_IC};
         if (state == IDLE && state_n != IDLE) last_gnt <= state_n == GNT_DC;
      end
   end
   // an abandoned transaction (reset in flight) must never ack
   always_comb begin
      state_n      = state;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      ic_ack_o     = 1'b0;
      dc_ack_o     = 1'b0;
      ic_data_o    = '0;
      dc_data_o    = '0;
      case (state)
         IDLE: begin
            if (ic_enable_i | dc_enable_i) state_n = pick_dc ? GNT_DC : GNT_IC;
         end
         GNT_IC: begin
            mem_enable_o = 1'b1;
            mem_write_o  = ic_write_i;
            mem_addr_o   = ic_addr_i;
            mem_data_o   = ic_data_i;
            ic_ack_o     = mem_ack_i & ~rst_i;
            ic_data_o    = ic_ack_o ? mem_data_i : '0;
            if (mem_ack_i | ~ic_enable_i) state_n = IDLE;
         end
         GNT_DC: begin
            mem_enable_o = 1'b1;
            mem_write_o  = dc_write_i;
            mem_addr_o   = dc_addr_i;
            mem_data_o   = dc_data_i;
            dc_ack_o     = mem_ack_i & ~rst_i;
            dc_data_o    = dc_ack_o ? mem_data_i : '0;
            if (mem_ack_i | ~dc_enable_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level owner model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 256;
   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ic_enable_i, ic_write_i, dc_enable_i, dc_write_i, mem_ack_i;
   logic [AW-1:0] ic_addr_i, dc_addr_i;
   logic [DW-1:0] ic_data_i, dc_data_i, mem_data_i;
   logic [DW-1:0] ic_data_o, dc_data_o, mem_data_o;
   logic          ic_ack_o, dc_ack_o, mem_enable_o, mem_write_o;
   logic [AW-1:0] mem_addr_o;
   logic [1:0]    grant_o;
   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ic_enable_i(ic_enable_i), .ic_write_i(ic_write_i), .ic_addr_i(ic_addr_i),
      .ic_data_i(ic_data_i), .ic_data_o(ic_data_o), .ic_ack_o(ic_ack_o),
      .dc_enable_i(dc_enable_i), .dc_write_i(dc_write_i), .dc_addr_i(dc_addr_i),
      .dc_data_i(dc_data_i), .dc_data_o(dc_data_o), .dc_ack_o(dc_ack_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .grant_o(grant_o)
   );
   always #5 clk_i = ~clk_i;
   int vectors = 0;
   int miscompares = 0;
   // model: who owns the memory (0 none, 1 icache, 2 dcache) and who owned it last
   int own = 0;
   int last = 1;
   logic          en[0:2], wr[0:2], ack[0:2];
   logic [AW-1:0] ad[0:2];
   logic [DW-1:0] dt[0:2];
   logic          seen_ic_ack, seen_dc_ack, seen_wr;
   logic [1:0]    seen_grant;
   logic [AW-1:0] seen_addr;
   logic [DW-1:0] seen_mdata, seen_ic_data;
   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step();
      int w;
      @(negedge clk_i);
      en[0] = 1'b0; wr[0] = 1'b0; ad[0] = '0; dt[0] = '0; ack[0] = 1'b0;
      en[1] = ic_enable_i; wr[1] = ic_write_i; ad[1] = ic_addr_i; dt[1] = ic_data_i;
      en[2] = dc_enable_i; wr[2] = dc_write_i; ad[2] = dc_addr_i; dt[2] = dc_data_i;
      for (int k = 1; k <= 2; k++) ack[k] = (own == k) && mem_ack_i && !rst_i;
      chk("grant", grant_o, own[1:0]);
      chk("mem_en", mem_enable_o, own != 0);
      chk("mem_wr", mem_write_o, wr[own]);
      chk("mem_addr", mem_addr_o, ad[own]);
      chk("mem_data", mem_data_o, dt[own]);
      chk("ic_ack", ic_ack_o, ack[1]);
      chk("dc_ack", dc_ack_o, ack[2]);
      chk("ic_data", ic_data_o, ack[1] ? mem_data_i : '0);
      chk("dc_data", dc_data_o, ack[2] ? mem_data_i : '0);
      seen_ic_ack = ic_ack_o; seen_dc_ack = dc_ack_o; seen_grant = grant_o;
      seen_addr = mem_addr_o; seen_wr = mem_write_o; seen_mdata = mem_data_o; seen_ic_data = ic_data_o;
      if (rst_i) begin
         own = 0; last = 1;
      end else if (own == 0) begin
         if (en[1] || en[2]) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = (en[1] && en[2]) ? 3 - last : (en[2] ? 2 : 1);
`else
            w = en[2] ? 2 : 1;
`endif
            own = w; last = w;
         end
      end else if (ack[own] || !en[own]) own = 0;
      @(posedge clk_i);
      #1;
   endtask
   task automatic quiet();
      rst_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
      ic_enable_i = 1'b0; ic_write_i = 1'b0; ic_addr_i = '0; ic_data_i = '0;
      dc_enable_i = 1'b0; dc_write_i = 1'b0; dc_addr_i = '0; dc_data_i = '0;
   endtask
   task automatic do_reset();
      quiet();
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      step();
   endtask
   task automatic serve_pair(input string tag);
      int order[$];
      int both = 0;
      ic_enable_i = 1'b1; ic_addr_i = 32'h200;
      dc_enable_i = 1'b1; dc_addr_i = 32'h300;
      for (int i = 0; i < 40 && order.size() < 2; i++) begin
         mem_ack_i = (i % 3 == 2);
         mem_data_i = {8{$urandom}};
         step();
         if (seen_ic_ack && seen_dc_ack) both++;
         if (seen_dc_ack) begin order.push_back(2); dc_enable_i = 1'b0; end
         if (seen_ic_ack) begin order.push_back(1); ic_enable_i = 1'b0; end
      end
      mem_ack_i = 1'b0;
      chk({tag, "_served"}, order.size(), 2);
      if (order.size() == 2) begin
         chk({tag, "_first"}, order[0], 2);
         chk({tag, "_second"}, order[1], 1);
      end
      chk({tag, "_coincide"}, both, 0);
      step();
   endtask
   task automatic drive(input logic acked, inout logic e, inout logic w,
                        inout logic [AW-1:0] a, inout logic [DW-1:0] d);
      if (e && !acked && $urandom_range(0, 99) != 0) return;
      e = ($urandom_range(0, 2) == 0);
      w = $urandom_range(0, 1);
      a = $urandom;
      d = {8{$urandom}};
   endtask
   initial begin
      logic [DW-1:0] line;
      // single icache read
      do_reset();
      ic_enable_i = 1'b1; ic_addr_i = 32'h100;
      step();
      chk("idle_before_grant", seen_grant, 2'b00);
      for (int i = 0; i < 9; i++) step();
      chk("ic_grant", seen_grant, 2'b01);
      chk("ic_addr", seen_addr, 32'h100);
      mem_ack_i = 1'b1; mem_data_i = {8{32'hCAFE_0123}};
      line = mem_data_i;
      step();
      chk("ic_ack_pulse", seen_ic_ack, 1'b1);
      chk("ic_line", seen_ic_data, line);
      ic_enable_i = 1'b0; mem_ack_i = 1'b0;
      step();
      chk("idle_after_ack", seen_grant, 2'b00);
      // simultaneous requests, twice from reset
      do_reset();
      serve_pair("pair1");
      serve_pair("pair2");
      // ack in idle is ignored; dcache write
      do_reset();
      mem_ack_i = 1'b1;
      step();
      step();
      chk("idle_ack_ignored", {seen_ic_ack, seen_dc_ack, seen_grant}, 4'b0);
      mem_ack_i = 1'b0;
      dc_enable_i = 1'b1; dc_write_i = 1'b1; dc_addr_i = 32'h40; dc_data_i = {32{8'hA5}};
      step();
      step();
      chk("dc_write_qual", seen_wr, 1'b1);
      chk("dc_write_line", seen_mdata, {32{8'hA5}});
      mem_ack_i = 1'b1;
      step();
      chk("dc_write_ack", seen_dc_ack, 1'b1);
      quiet();
      step();
      // reset in the middle of a dcache grant
      do_reset();
      dc_enable_i = 1'b1; dc_addr_i = 32'h80;
      repeat (4) step();
      rst_i = 1'b1; dc_enable_i = 1'b0;
      step();
      rst_i = 1'b0;
      step();
      mem_ack_i = 1'b1;
      step();
      chk("late_ack_dropped", {seen_dc_ack, seen_grant}, 3'b0);
      mem_ack_i = 1'b0; dc_enable_i = 1'b1;
      step();
      step();
      chk("regrant_dc", seen_grant, 2'b10);
      mem_ack_i = 1'b1;
      step();
      chk("regrant_ack", seen_dc_ack, 1'b1);
      quiet();
      step();
      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_i = ($urandom_range(0, 199) == 0);
         drive(ack[1], ic_enable_i, ic_write_i, ic_addr_i, ic_data_i);
         drive(ack[2], dc_enable_i, dc_write_i, dc_addr_i, dc_data_i);
         mem_ack_i = ($urandom_range(0, 3) == 0);
         mem_data_i = {8{$urandom}};
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
